// File: rtl/prime_sieve_master.sv
// prime_sieve_master: bus master that hands a sieve limit to a prime-number
// responder, waits for it to build its isPrime table, then reads back every
// odd candidate from 3 up to the limit and counts the primes. It reports the
// run length, flags limits with a well-known prime count, and aborts the run
// with err_o if the responder stops acknowledging.
module prime_sieve_master #(
    parameter int PRIME_BITS  = 20,
    parameter int CYCLE_BITS  = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [PRIME_BITS-1:0] max_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [PRIME_BITS-1:0] count_o,
    output logic [CYCLE_BITS-1:0] cycles_o,
    output logic                  known_o,
    output logic                  pass_o,
    output logic                  err_o,
    output logic [PRIME_BITS-1:0] m_adr_o,
    output logic [PRIME_BITS-1:0] m_dat_o,
    input  logic                  m_dat_i,
    output logic                  m_we_o,
    output logic                  m_stb_o,
    input  logic                  m_ack_i,
    input  logic                  m_stall_i
);

    typedef enum logic [6:0] {
        IDLE       = 7'b000_0001,
        WR_STB     = 7'b000_0010,
        WR_ACK     = 7'b000_0100,
        SIEVE_WAIT = 7'b000_1000,
        RD_STB     = 7'b001_0000,
        RD_ACK     = 7'b010_0000,
        FINISH     = 7'b100_0000
    } state_t;

    localparam int AW1      = PRIME_BITS + 1;
    localparam int TMO_BITS = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(ACK_TIMEOUT - 1);

    // Reference prime counts for the classic limits; zero means "not a known limit".
    function automatic logic [31:0] known_count(input logic [31:0] lim);
        logic [31:0] res;
        case (lim)
            32'd10:      res = 32'd4;
            32'd100:     res = 32'd25;
            32'd1000:    res = 32'd168;
            32'd10000:   res = 32'd1229;
            32'd100000:  res = 32'd9592;
            32'd1000000: res = 32'd78498;
            default:     res = 32'd0;
        endcase
        return res;
    endfunction

    state_t                state_q, state_d;
    logic [PRIME_BITS-1:0] max_q, max_d;
    logic [PRIME_BITS-1:0] count_q, count_d;
    logic [CYCLE_BITS-1:0] cycles_q, cycles_d;
    logic [PRIME_BITS-1:0] adr_q, adr_d;
    logic [PRIME_BITS-1:0] dat_q, dat_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  known_q, known_d;
    logic                  pass_q, pass_d;
    logic [TMO_BITS-1:0]   tmo_q, tmo_d;
    logic                  first_q, first_d;
    logic [AW1-1:0]        adr_nxt_d;
    logic [31:0]           ref_cnt_d;

    // Widened next-address so a limit of all-ones cannot wrap back to a small address.
    always_comb begin
        adr_nxt_d = {1'b0, adr_q} + AW1'(2);
        ref_cnt_d = known_count(32'(max_q));
    end

    // Next-state, datapath updates and the combinational strobe (gated by stall).
    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        count_d  = count_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        known_d  = known_q;
        pass_d   = pass_q;
        tmo_d    = tmo_q;
        first_d  = first_q;
        m_stb_o  = 1'b0;
        m_we_o   = 1'b0;
        if (busy_q && (cycles_q != {CYCLE_BITS{1'b1}})) begin
            cycles_d = cycles_q + CYCLE_BITS'(1);
        end else begin
            cycles_d = cycles_q;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    max_d    = max_i;
                    dat_d    = max_i;
                    adr_d    = '0;
                    count_d  = '0;
                    cycles_d = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = WR_STB;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_STB: begin
                if (!m_stall_i) begin
                    m_stb_o = 1'b1;
                    m_we_o  = 1'b1;
                    tmo_d   = '0;
                    state_d = WR_ACK;
                end else begin
                    state_d = WR_STB;
                end
            end
            WR_ACK: begin
                if (m_ack_i) begin
                    first_d = 1'b1;
                    state_d = SIEVE_WAIT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    tmo_d = tmo_q + TMO_BITS'(1);
                end
            end
            SIEVE_WAIT: begin
                // The responder raises stall together with its ack, so the
                // first cycle here is never trusted as "sieve finished".
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!m_stall_i) begin
                    count_d = (max_q >= PRIME_BITS'(2)) ? PRIME_BITS'(1) : PRIME_BITS'(0);
                    if (max_q >= PRIME_BITS'(3)) begin
                        adr_d   = PRIME_BITS'(3);
                        state_d = RD_STB;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    state_d = SIEVE_WAIT;
                end
            end
            RD_STB: begin
                if (!m_stall_i) begin
                    m_stb_o = 1'b1;
                    tmo_d   = '0;
                    state_d = RD_ACK;
                end else begin
                    state_d = RD_STB;
                end
            end
            RD_ACK: begin
                if (m_ack_i) begin
                    count_d = count_q + PRIME_BITS'(m_dat_i);
                    if (adr_nxt_d <= {1'b0, max_q}) begin
                        adr_d   = adr_nxt_d[PRIME_BITS-1:0];
                        state_d = RD_STB;
                    end else begin
                        state_d = FINISH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    tmo_d = tmo_q + TMO_BITS'(1);
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                known_d = (ref_cnt_d != 32'd0);
                pass_d  = (ref_cnt_d != 32'd0) && !err_q && (32'(count_q) == ref_cnt_d);
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            max_q    <= '0;
            count_q  <= '0;
            cycles_q <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            known_q  <= 1'b0;
            pass_q   <= 1'b0;
            tmo_q    <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            max_q    <= max_d;
            count_q  <= count_d;
            cycles_q <= cycles_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            known_q  <= known_d;
            pass_q   <= pass_d;
            tmo_q    <= tmo_d;
            first_q  <= first_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign count_o  = count_q;
    assign cycles_o = cycles_q;
    assign known_o  = known_q;
    assign pass_o   = pass_q;
    assign err_o    = err_q;
    assign m_adr_o  = adr_q;
    assign m_dat_o  = dat_q;

endmodule

// File: doc/prime_sieve_master.md
PRIME_SIEVE_MASTER -- requirements
Module: prime_sieve_master

Interface
REQ-001 SHALL have parameter PRIME_BITS, default 20: width of the sieve limit, bus address and count.
REQ-002 SHALL have parameter CYCLE_BITS, default 32: width of the run-time cycle counter.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15: max cycles to wait for m_ack_i after a strobe.
REQ-004 SHALL have ports:
- clk_i, in, 1: single clock; all logic on its rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- start_i, in, 1: begin a run; sampled only in IDLE.
- max_i, in, PRIME_BITS: sieve limit, captured on accepted start.
- busy_o, out, 1: high from accepted start until done_o.
- done_o, out, 1: one-cycle pulse when a run ends.
- count_o, out, PRIME_BITS: number of primes in 0..max, held until the next start.
- cycles_o, out, CYCLE_BITS: cycles from start to done, held.
- known_o, out, 1: captured max is 10, 100, 1000, 10000, 100000 or 1000000.
- pass_o, out, 1: known_o and count_o equal the table value (4, 25, 168, 1229, 9592, 78498 respectively).
- err_o, out, 1: run aborted on an ack timeout.
- m_adr_o, out, PRIME_BITS: bus address.
- m_dat_o, out, PRIME_BITS: bus write data.
- m_dat_i, in, 1: isPrime read bit.
- m_we_o, out, 1: write enable.
- m_stb_o, out, 1: strobe.
- m_ack_i, in, 1: responder ack.
- m_stall_i, in, 1: responder busy.

Function
REQ-005 SHALL use one-hot states IDLE, WR_STB, WR_ACK, SIEVE_WAIT, RD_STB, RD_ACK, FINISH.
REQ-006 IDLE + start_i: capture max_i; clear count, cycles and err; set busy_o; go to WR_STB. start_i outside IDLE SHALL be ignored.
REQ-007 WR_STB: while m_stall_i is high, keep m_stb_o low and wait.
REQ-008 WR_STB, first cycle with m_stall_i low: drive m_stb_o=1, m_we_o=1, m_dat_o=max for exactly one cycle; go to WR_ACK.
REQ-009 WR_ACK: on m_ack_i go to SIEVE_WAIT.
REQ-010 SIEVE_WAIT: ignore m_stall_i on the cycle m_ack_i is seen (the responder raises stall that same cycle); afterwards wait until m_stall_i is low.
REQ-011 SIEVE_WAIT exit: count = 1 if max>=2, else 0. If max>=3, set address 3 and go to RD_STB; else go to FINISH.
REQ-012 RD_STB: when m_stall_i is low, drive m_stb_o=1, m_we_o=0, m_adr_o=address for one cycle; go to RD_ACK.
REQ-013 RD_ACK: hold m_adr_o unchanged through the ack cycle.
REQ-014 RD_ACK, on m_ack_i: sample m_dat_i in that same cycle; count += m_dat_i.
REQ-015 RD_ACK, after the sample: if address+2 <= max, address += 2 and return to RD_STB; else go to FINISH.
REQ-016 The address+2 comparison SHALL be PRIME_BITS+1 wide so max = 2^PRIME_BITS-1 cannot wrap.
REQ-017 Throughput: each odd address costs exactly 2 cycles when the responder acks in the next cycle with stall low.
REQ-018 Timeout: in WR_ACK or RD_ACK, if m_ack_i is absent for ACK_TIMEOUT consecutive cycles, set err_o and go to FINISH with count as accumulated.
REQ-019 cycles_o SHALL increment every cycle busy_o is high and saturate at all-ones.
REQ-020 FINISH: pulse done_o for one cycle, clear busy_o, update known_o/pass_o from captured max and count, return to IDLE.
REQ-021 pass_o SHALL be 0 whenever err_o is 1.
REQ-022 m_stb_o SHALL never be high in two consecutive cycles, and never while m_stall_i is high.
REQ-023 m_we_o SHALL be 0 whenever m_stb_o is 0.

Reset
REQ-024 On rst_i, from any state including mid-run: state=IDLE; m_stb_o, m_we_o, busy_o, done_o, err_o, known_o, pass_o = 0; count_o, cycles_o, m_adr_o, m_dat_o = 0.
REQ-025 All reset values SHALL take effect on the first clock edge with rst_i high.
REQ-026 A start_i asserted together with rst_i SHALL be ignored.

Verification
REQ-027 Against prime_number_core, start with max=10 -> one write of 10; reads of 3,5,7,9 only; count_o=4, known_o=1, pass_o=1, err_o=0.
REQ-028 max=1000 -> count_o=168, pass_o=1. Repeat with a responder model that forces isPrime=0 at 997 -> count_o=167, pass_o=0.
REQ-029 max=2 -> count_o=1 with no read strobes. max=1 -> count_o=0. Both: known_o=0, done_o single pulse.
REQ-030 PRIME_BITS=20, max=1048575 -> count_o=82025, last read address 1048575, no address wrap, known_o=0.
REQ-031 Responder model withholds ack on read 3 for 15 cycles -> err_o=1, pass_o=0, done_o pulse, back in IDLE; start_i during the run is ignored.
REQ-032 rst_i asserted mid-scan (max=100000) -> next cycle all outputs at reset values, m_stb_o=0; a following run with max=100 -> count_o=25, pass_o=1.
